// File: rtl/puf_chal_seq.sv
// puf_chal_seq: challenge sequencer for the arbiter PUF. Steps the
// challenge LFSR, lets the challenge settle, fires the race, samples
// the arbiter and hands {challenge, response} pairs downstream.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   start, num_chal   - begin a run of num_chal CRPs (sampled in IDLE)
//   abort             - cancel the run in progress, no done pulse
//   lfsr_en           - one-cycle LFSR step strobe
//   lfsr_state        - current LFSR challenge
//   race_launch       - one-cycle race start pulse to the PUF core
//   puf_resp          - arbiter output
//   out_valid/ready   - CRP handshake
//   out_chal/resp/idx - CRP payload and 0-based index
//   busy, done        - run status, done pulses once at end of run
//
// Build option: define PUF_MAJORITY_VOTE_EN to race each challenge
// three times and report the majority response.

module puf_chal_seq #(
    parameter int W         = 64,
    parameter int SETTLE    = 4,
    parameter int RESP_WAIT = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_chal,
    output logic             lfsr_en,
    input  logic [W-1:0]     lfsr_state,
    output logic             race_launch,
    input  logic             puf_resp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_chal,
    output logic             out_resp,
    output logic [CNT_W-1:0] out_idx,
    output logic             busy,
    output logic             done
);

    localparam int TW = 16;
    localparam logic [TW-1:0]    T_ONE       = 1;
    localparam logic [CNT_W-1:0] C_ONE       = 1;
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0]    WAIT_LAST   = TW'(RESP_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_LAUNCH,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [TW-1:0]    r_tmr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_idx;
    logic [W-1:0]     r_chal;
    logic             r_resp;

    logic w_settle_last;
    logic w_wait_last;
    logic w_last_crp;
    logic w_abort;
    logic w_final_race;

`ifdef PUF_MAJORITY_VOTE_EN
    // r_rep counts completed races of the current challenge (0..2)
    logic [1:0] r_rep;
    logic [1:0] r_samp;
    logic       w_maj;

    assign w_final_race = (r_rep == 2'd2);
    assign w_maj = (r_samp[0] & r_samp[1]) |
                   (r_samp[0] & puf_resp) |
                   (r_samp[1] & puf_resp);
`else
    assign w_final_race = 1'b1;
`endif

    assign w_settle_last = (r_tmr == SETTLE_LAST);
    assign w_wait_last   = (r_tmr == WAIT_LAST);
    assign w_last_crp    = (r_idx == r_cnt - C_ONE);
    assign w_abort       = abort && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt       = r_state;
        lfsr_en     = 1'b0;
        race_launch = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt = (num_chal != '0) ? S_STEP : S_DONE;
                end
            end
            S_STEP: begin
                lfsr_en = 1'b1;
                w_nxt   = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_settle_last) begin
                    w_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                race_launch = 1'b1;
                w_nxt       = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_last) begin
                    w_nxt = w_final_race ? S_OUT : S_LAUNCH;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nxt = w_last_crp ? S_DONE : S_STEP;
                end
            end
            S_DONE: begin
                done  = 1'b1;
                w_nxt = S_IDLE;
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
        // abort overrides everything, including an OUT handshake
        if (w_abort) begin
            w_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_chal <= '0;
            r_resp <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            r_rep  <= '0;
            r_samp <= '0;
`endif
        end else begin
            // timer restarts on every state change
            r_tmr <= (w_nxt != r_state) ? '0 : r_tmr + T_ONE;
            if (w_abort) begin
                r_idx  <= '0;
                r_chal <= '0;
                r_resp <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_cnt <= num_chal;
                            r_idx <= '0;
                        end
                    end
                    S_STEP: begin
`ifdef PUF_MAJORITY_VOTE_EN
                        r_rep <= '0;
`endif
                    end
                    S_LAUNCH: begin
                        r_chal <= lfsr_state;
                    end
                    S_WAIT: begin
                        if (w_wait_last) begin
`ifdef PUF_MAJORITY_VOTE_EN
                            r_samp[r_rep[0]] <= puf_resp;
                            r_rep            <= r_rep + 2'd1;
                            if (w_final_race) begin
                                r_resp <= w_maj;
                            end
`else
                            r_resp <= puf_resp;
`endif
                        end
                    end
                    S_OUT: begin
                        if (out_ready && !w_last_crp) begin
                            r_idx <= r_idx + C_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign out_chal = r_chal;
    assign out_resp = r_resp;
    assign out_idx  = r_idx;

endmodule

// File: doc/puf_chal_seq.md
# puf_chal_seq

Challenge sequencer for the arbiter PUF. Steps the 64-bit challenge LFSR, waits for the challenge to settle on the delay chains, fires the race, samples the arbiter output, and hands each {challenge, response} pair downstream over a valid/ready interface. It sits between the LFSR and the PUF core on one side and the CRP capture/UART path on the other. One run produces `num_chal` CRPs.

## Interface
- `W`, 64, challenge width; must match the LFSR width.
- `SETTLE`, 4, idle cycles between the LFSR step and the race launch; must be ≥1.
- `RESP_WAIT`, 8, cycles from the launch pulse to sampling `puf_resp`; must be ≥1.
- `CNT_W`, 16, width of the challenge count and index.

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a run when sampled in IDLE; ignored otherwise.
- `abort` in 1: synchronous cancel of the run in progress.
- `num_chal` in CNT_W: number of CRPs; sampled with `start`.
- `lfsr_en` out 1: one-cycle step strobe to the LFSR `enable`.
- `lfsr_state` in W: current LFSR challenge.
- `race_launch` out 1: one-cycle race start pulse to the PUF.
- `puf_resp` in 1: arbiter output.
- `out_valid` out 1: CRP available.
- `out_ready` in 1: downstream accepts the CRP.
- `out_chal` out W: challenge of the current CRP.
- `out_resp` out 1: response of the current CRP.
- `out_idx` out CNT_W: 0-based index of the current CRP.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- States: IDLE, STEP, SETTLE, LAUNCH, WAIT, OUT, DONE.
- IDLE → STEP on `start` with `num_chal`≠0. Latch the count and clear `out_idx`.
- IDLE → DONE on `start` with `num_chal`=0. No LFSR step and no race.
- STEP: `lfsr_en`=1 for exactly one cycle, then → SETTLE.
- SETTLE: lasts exactly SETTLE cycles, then → LAUNCH.
- LAUNCH: `race_launch`=1 for one cycle. `out_chal` is loaded from `lfsr_state` on this cycle. Then → WAIT.
- WAIT: lasts RESP_WAIT cycles. On the last WAIT cycle `puf_resp` is registered into `out_resp`. Then → OUT.
- OUT: `out_valid`=1, and `out_chal`, `out_resp` and `out_idx` are held stable until `out_ready`.
  - On handshake, if `out_idx`=count−1 → DONE.
  - Otherwise `out_idx`+1 → STEP.
- DONE: `done`=1 for one cycle, then → IDLE.
- `abort` in any non-IDLE state → IDLE on the next edge. Drops `out_valid` without a handshake, with no `done` pulse and no further `lfsr_en`.
- Simultaneous `abort` and an OUT handshake: abort wins and `out_idx` does not advance.
- `start` while busy is ignored.
- `lfsr_en` and `race_launch` never assert in the same cycle.
- Reset (at any time, including mid-run) → IDLE with all outputs 0: `out_chal`=0, `out_idx`=0, `busy`=0, `done`=0, `out_valid`=0.
- The LFSR is not reset by this block.

## Timing
- `start` is sampled at cycle 0. STEP is at cycle 1 and LAUNCH at cycle S+2.
- First `out_valid` at cycle S+R+3 (S=SETTLE, R=RESP_WAIT), i.e. cycle 15 at defaults.
- With `out_ready` held high, one CRP completes every S+R+3 cycles.
- The `done` pulse is in the cycle after the final handshake. `busy` falls one cycle after that.
- `out_ready` may be high before `out_valid`. The handshake occurs in the first OUT cycle.

## Configuration
- `PUF_MAJORITY_VOTE_EN` defined: each challenge runs three LAUNCH+WAIT pairs back-to-back, with no LFSR step between them.
  - `out_resp` is the majority of the three samples.
  - First `out_valid` moves to cycle S+3R+5; the per-CRP period becomes S+3R+5.
- Undefined: a single race per challenge, as described above.

## Test plan
- LFSR freshly reset, `num_chal`=2, `out_ready`=1, defaults:
  - `out_valid` at cycle 15 with `out_chal`=64'hFFFF_FFFF_FFFF_FFFE, `out_idx`=0.
  - Second CRP with `out_chal`=64'hFFFF_FFFF_FFFF_FFFC, `out_idx`=1.
  - `done` 1 cycle after the second handshake.
- `puf_resp` driven 1 during the sampling cycle and 0 elsewhere → `out_resp`=1. Driving 1 only during LAUNCH → `out_resp`=0.
- Backpressure: `out_ready`=0 for 10 cycles in OUT → `out_valid` and all data stable, no `lfsr_en`. Releasing `out_ready` → handshake in that cycle.
- `num_chal`=0 with `start` → `done` at cycle 1, zero `lfsr_en` and zero `race_launch` pulses.
- `abort` in WAIT of CRP 1 of 3, then `rst` mid-SETTLE of a new run → both return to IDLE next edge with no `done` and all outputs 0.
- With `PUF_MAJORITY_VOTE_EN` defined:
  - `puf_resp` samples 1,0,1 → `out_resp`=1 with `out_valid` at cycle 33.
  - Samples 0,0,1 → `out_resp`=0.
